// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns execute-stage load/store requests into
// single-beat bus transactions with byte lanes, alignment checks and a timeout.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        flush,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg, wdata_reg, load_data_reg;
  logic [3:0]  be_reg;
  logic [1:0]  off_reg;
  logic        we_reg, load_reg, err_reg;

  logic        size_byte, size_half, request, is_misaligned, accept, expire;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  // Undefined funct3 encodings fall through to word size.
  assign size_byte = (funct3 == 3'b000) || (funct3 == 3'b100);
  assign size_half = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign request   = (mem_read | mem_write) & ~flush;
  assign is_misaligned = size_half ? addr[0] : (!size_byte && (addr[1:0] != 2'b00));

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = store_data;
    if (size_byte) begin
      be_calc    = 4'b0001 << addr[1:0];
      wdata_calc = {4{store_data[7:0]}};
    end else if (size_half) begin
      be_calc    = 4'b0011 << addr[1:0];
      wdata_calc = {2{store_data[15:0]}};
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall      = 1'b0;
    misaligned = 1'b0;
    accept     = 1'b0;
    expire     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (request) begin
          if (is_misaligned) begin
            misaligned = 1'b1;
          end else begin
            accept     = 1'b1;
            stall      = 1'b1;
            cnt_next   = 8'd0;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        // flush is deliberately not looked at here: an issued beat always completes.
        stall = 1'b1;
        if (bus_ready) begin
          state_next = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          expire     = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 8'd0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      be_reg        <= 4'd0;
      off_reg       <= 2'd0;
      we_reg        <= 1'b0;
      load_reg      <= 1'b0;
      err_reg       <= 1'b0;
      load_data_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= expire;
      if (accept) begin
        addr_reg  <= {addr[31:2], 2'b00};
        off_reg   <= addr[1:0];
        we_reg    <= mem_write;
        load_reg  <= ~mem_write;
        be_reg    <= be_calc;
        wdata_reg <= wdata_calc;
      end
      if (state_reg == REQ && bus_ready && load_reg) begin
        load_data_reg <= bus_rdata >> {off_reg, 3'b000};
      end else if (expire && load_reg) begin
        load_data_reg <= 32'd0;
      end
    end
  end

  assign bus_valid  = (state_reg == REQ);
  assign bus_we     = we_reg;
  assign bus_addr   = addr_reg;
  assign bus_wdata  = wdata_reg;
  assign bus_be     = be_reg;
  assign load_data  = load_data_reg;
  assign load_valid = (state_reg == DONE) && load_reg;
  assign bus_err    = err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: transaction-level reference model compared every
// cycle, plus literal expectations for the scenarios with hand-derived results.
module tb_dmem_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write, flush, bus_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, bus_rdata;
  logic        bus_valid, bus_we, load_valid, stall, misaligned, bus_err;
  logic [31:0] bus_addr, bus_wdata, load_data;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .flush(flush),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_valid(bus_valid),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .load_data(load_data), .load_valid(load_valid), .stall(stall),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int nbytes(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit aligned(input logic [2:0] f, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(f)) == 0;
  endfunction

  // Reference model: one outstanding transaction, then a single completion cycle.
  bit          m_live = 0, busy = 0, fin = 0, m_we = 0, m_load = 0, m_err = 0;
  int          waited = 0, m_off = 0, n = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_ld = 0;
  logic [3:0]  m_be = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1; busy = 0; fin = 0; m_we = 0; m_load = 0; m_err = 0;
      m_addr = 0; m_wdata = 0; m_ld = 0; m_be = 0;
    end else if (m_live) begin
      if (fin) begin
        fin = 0; m_err = 0;
      end else if (busy) begin
        if (bus_ready) begin
          if (m_load) m_ld = bus_rdata >> (8 * m_off);
          busy = 0; fin = 1;
        end else begin
          waited++;
          if (waited == TO) begin
            busy = 0; fin = 1; m_err = 1;
            if (m_load) m_ld = 0;
          end
        end
      end else if ((mem_read | mem_write) && !flush && aligned(funct3, addr)) begin
        n       = nbytes(funct3);
        m_off   = int'(addr % 4);
        m_addr  = (addr / 4) * 4;
        m_we    = mem_write;
        m_load  = !mem_write;
        m_be    = (n == 4) ? 4'hF : 4'(((1 << n) - 1) << m_off);
        m_wdata = (n == 1) ? store_data[7:0] * 32'h01010101 :
                  (n == 2) ? store_data[15:0] * 32'h00010001 : store_data;
        busy = 1; waited = 0;
      end
    end
  end

  bit want_now, ok_now;
  always @(negedge clk) begin
    if (m_live) begin
      want_now = (mem_read | mem_write) && !flush && !busy && !fin;
      ok_now   = aligned(funct3, addr);
      chk("m_bus_valid", bus_valid, busy);
      chk("m_stall", stall, busy | (want_now & ok_now));
      chk("m_misaligned", misaligned, want_now & !ok_now);
      chk("m_load_valid", load_valid, fin & m_load);
      chk("m_bus_err", bus_err, fin & m_err);
      chk("m_load_data", load_data, m_ld);
      chk("m_bus_we", bus_we, m_we);
      chk("m_bus_addr", bus_addr, m_addr);
      chk("m_bus_be", bus_be, m_be);
      chk("m_bus_wdata", bus_wdata, m_wdata);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected end by 1000000");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a, sd, rd;
    logic [3:0]  be;
    logic [31:0] wd, ld;
  } vec_t;

  vec_t vecs[7];
  int   cnt, vcnt, lvcnt;

  initial begin
    rst = 1; mem_read = 0; mem_write = 0; flush = 0; bus_ready = 0;
    funct3 = 0; addr = 0; store_data = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_stall", stall, 0);
    step(); rst = 0;
    step();

    // LB 0x103, immediate ready
    mem_read = 1; funct3 = 3'b000; addr = 32'h103; bus_ready = 1; bus_rdata = 32'hAABBCCDD;
    $display("txn LB addr=0x103");
    @(negedge clk); chk("lb_accept_stall", stall, 1);
    step(); mem_read = 0;
    @(negedge clk);
    chk("lb_bus_valid", bus_valid, 1);
    chk("lb_bus_addr", bus_addr, 32'h100);
    chk("lb_bus_be", bus_be, 4'b1000);
    step();
    @(negedge clk);
    chk("lb_load_valid", load_valid, 1);
    chk("lb_load_data", load_data, 32'h000000AA);
    chk("lb_stall_done", stall, 0);
    step(); bus_ready = 0;

    // SH 0x202 with three wait cycles
    mem_write = 1; funct3 = 3'b001; addr = 32'h202; store_data = 32'h1234ABCD;
    $display("txn SH addr=0x202 wait=3");
    cnt = 0;
    @(negedge clk); if (stall) cnt++;
    step(); mem_write = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_ready = 1;
      @(negedge clk);
      chk("sh_bus_valid", bus_valid, 1);
      chk("sh_bus_wdata", bus_wdata, 32'hABCDABCD);
      chk("sh_bus_be", bus_be, 4'b1100);
      chk("sh_bus_addr", bus_addr, 32'h200);
      if (stall) cnt++;
      step();
    end
    bus_ready = 0;
    @(negedge clk);
    chk("sh_no_load_valid", load_valid, 0);
    chk("sh_stall_done", stall, 0);
    chk("sh_stall_cycles", cnt, 5);
    step();

    // LW misaligned
    mem_read = 1; funct3 = 3'b010; addr = 32'h101;
    $display("txn LW addr=0x101 misaligned");
    @(negedge clk);
    chk("mis_flag", misaligned, 1);
    chk("mis_stall", stall, 0);
    chk("mis_bus_valid", bus_valid, 0);
    step(); mem_read = 0;
    @(negedge clk);
    chk("mis_pulse_end", misaligned, 0);
    chk("mis_no_bus", bus_valid, 0);
    step();

    // LW timeout
    mem_read = 1; funct3 = 3'b010; addr = 32'h300; bus_ready = 0;
    $display("txn LW addr=0x300 timeout");
    step(); mem_read = 0; vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_valid) vcnt++;
      chk("to_no_err_early", bus_err, 0);
      step();
    end
    @(negedge clk);
    chk("to_bus_err", bus_err, 1);
    chk("to_load_data", load_data, 0);
    chk("to_bus_valid_off", bus_valid, 0);
    chk("to_req_cycles", vcnt, 4);
    step();
    @(negedge clk);
    chk("to_err_pulse_end", bus_err, 0);
    chk("to_idle_stall", stall, 0);
    step();

    // reset during second REQ cycle, then a normal LW
    mem_read = 1; funct3 = 3'b010; addr = 32'h400; bus_ready = 0;
    $display("txn LW addr=0x400 reset mid-REQ");
    step(); mem_read = 0;
    step(); rst = 1;
    @(negedge clk); chk("rr_valid_before", bus_valid, 1);
    step(); rst = 0;
    @(negedge clk);
    chk("rr_bus_valid", bus_valid, 0);
    chk("rr_bus_addr", bus_addr, 0);
    chk("rr_bus_be", bus_be, 0);
    chk("rr_stall", stall, 0);
    step();
    mem_read = 1; addr = 32'h404; bus_ready = 1; bus_rdata = 32'h11223344;
    $display("txn LW addr=0x404 after reset");
    @(negedge clk); chk("rr_accept", stall, 1);
    step(); mem_read = 0;
    @(negedge clk); chk("rr_bus_addr2", bus_addr, 32'h404);
    step();
    @(negedge clk);
    chk("rr_load_valid", load_valid, 1);
    chk("rr_load_data", load_data, 32'h11223344);
    step(); bus_ready = 0;

    // flush blocks acceptance; held mem_read yields one transaction
    mem_read = 1; funct3 = 3'b010; addr = 32'h500; flush = 1; bus_ready = 1; bus_rdata = 32'hCAFEBABE;
    $display("txn LW addr=0x500 flush then held request");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("fl_stall", stall, 0);
      chk("fl_bus_valid", bus_valid, 0);
      step();
    end
    flush = 0; vcnt = 0; lvcnt = 0;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      @(negedge clk);
      if (bus_valid) vcnt++;
      if (load_valid) lvcnt++;
      step();
    end
    flush = 0; mem_read = 0;
    @(negedge clk);
    if (bus_valid) vcnt++;
    if (load_valid) lvcnt++;
    chk("fl_one_beat", vcnt, 1);
    chk("fl_one_load", lvcnt, 1);
    chk("fl_load_data", load_data, 32'hCAFEBABE);
    step(); bus_ready = 0;

    // size/lane table, one wait cycle each
    vecs[0] = '{1'b0, 3'b001, 32'h502, 32'h0, 32'hCAFEBABE, 4'b1100, 32'h0, 32'h0000CAFE};
    vecs[1] = '{1'b0, 3'b100, 32'h501, 32'h0, 32'hCAFEBABE, 4'b0010, 32'h0, 32'h00CAFEBA};
    vecs[2] = '{1'b0, 3'b101, 32'h500, 32'h0, 32'h89ABCDEF, 4'b0011, 32'h0, 32'h89ABCDEF};
    vecs[3] = '{1'b1, 3'b000, 32'h603, 32'h000000EF, 32'h0, 4'b1000, 32'hEFEFEFEF, 32'h0};
    vecs[4] = '{1'b1, 3'b010, 32'h604, 32'hDEADBEEF, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[5] = '{1'b1, 3'b011, 32'h608, 32'h01234567, 32'h0, 4'b1111, 32'h01234567, 32'h0};
    vecs[6] = '{1'b0, 3'b010, 32'h70C, 32'h0, 32'h5A5A0F0F, 4'b1111, 32'h0, 32'h5A5A0F0F};
    foreach (vecs[k]) begin
      $display("txn vec%0d we=%0d f3=%0d addr=0x%08h", k, vecs[k].we, vecs[k].f3, vecs[k].a);
      mem_write = vecs[k].we; mem_read = !vecs[k].we; funct3 = vecs[k].f3;
      addr = vecs[k].a; store_data = vecs[k].sd; bus_rdata = vecs[k].rd; bus_ready = 0;
      step(); mem_write = 0; mem_read = 0;
      @(negedge clk);
      chk("vec_bus_be", bus_be, vecs[k].be);
      if (vecs[k].we) chk("vec_bus_wdata", bus_wdata, vecs[k].wd);
      step(); bus_ready = 1;
      step(); bus_ready = 0;
      @(negedge clk);
      chk("vec_load_valid", load_valid, !vecs[k].we);
      if (!vecs[k].we) chk("vec_load_data", load_data, vecs[k].ld);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles bus_valid may wait for bus_ready before abort (1..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mem_read  input  1  load request from execute stage.
REQ-005 mem_write  input  1  store request from execute stage.
REQ-006 funct3  input  3  access size (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 addr  input  32  byte address (ALU result).
REQ-008 store_data  input  32  rs2 value for stores.
REQ-009 flush  input  1  pipeline flush; blocks acceptance of a new request.
REQ-010 bus_rdata  input  32  data memory read word.
REQ-011 bus_ready  input  1  memory accepts/completes the current beat.
REQ-012 bus_valid  output  1  transaction request to data memory.
REQ-013 bus_we  output  1  1 = write, 0 = read.
REQ-014 bus_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-015 bus_wdata  output  32  lane-replicated store data.
REQ-016 bus_be  output  4  byte enables.
REQ-017 load_data  output  32  read word shifted so addressed byte/half sits at bit 0 (sign/zero extension is done downstream by writeback).
REQ-018 load_valid  output  1  one-cycle pulse: load_data valid.
REQ-019 stall  output  1  hold pipeline stages upstream of memory.
REQ-020 misaligned  output  1  one-cycle pulse: misaligned access rejected.
REQ-021 bus_err  output  1  one-cycle pulse: transaction timed out.

Function
REQ-022 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-023 IDLE: request = (mem_read|mem_write) & ~flush; mem_write has priority when both are high.
REQ-024 Misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=0, is rejected: misaligned=1 (combinational, same cycle), no bus access, stall=0, stay IDLE.
REQ-025 Accepted aligned request in IDLE: stall=1 the same cycle (combinational); addr, we, be and wdata are registered; next state REQ.
REQ-026 bus_be: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<addr[1:0]; W 4'b1111; undefined funct3 is treated as W.
REQ-027 bus_wdata: B {4{sd[7:0]}}; H {2{sd[15:0]}}; W sd.
REQ-028 REQ: bus_valid=1 and stall=1; bus_addr, bus_we, bus_be and bus_wdata stay stable until bus_valid&bus_ready.
REQ-029 Handshake completes on the cycle bus_valid&bus_ready; a load registers bus_rdata>>(8*addr[1:0]) into load_data; next state DONE.
REQ-030 Timeout counter is cleared on entry to REQ and increments each REQ cycle without ready; reaching TIMEOUT forces DONE with bus_err=1 for one cycle and load_data=0.
REQ-031 DONE: stall=0; load_valid=1 for loads only; no new request accepted; next state IDLE.
REQ-032 flush in REQ is ignored; the transaction completes normally.
REQ-033 Minimum latency: accept cycle N, bus_valid in N+1, ready in N+1 -> load_valid/stall=0 in N+2.
REQ-034 load_data holds its value until the next completed load.

Reset
REQ-035 rst=1 at a clock edge forces IDLE, clears the timeout counter and load_data, and deasserts bus_valid from the next cycle. This applies even mid-REQ; the abandoned beat is not retried.
REQ-036 Reset values: bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, load_data=0, load_valid=0, misaligned=0, bus_err=0, stall=0.

Verification
REQ-037 LB addr=0x103, ready immediate, rdata=0xAABBCCDD -> bus_addr=0x100, bus_be=1000, load_data=0x000000AA, load_valid in cycle N+2.
REQ-038 SH addr=0x202, sd=0x1234ABCD, ready after 3 wait cycles -> bus_be=1100, bus_wdata=0xABCDABCD held stable 4 cycles, stall=1 for 5 cycles, no load_valid.
REQ-039 LW addr=0x101 -> misaligned=1 one cycle, bus_valid never asserted, stall=0.
REQ-040 LW with bus_ready held 0 and TIMEOUT=4 -> bus_err pulse after 4 REQ cycles, load_data=0, FSM returns to IDLE.
REQ-041 rst asserted during the 2nd REQ cycle -> bus_valid=0 the next cycle, all outputs at reset values, a new LW is then accepted normally.
REQ-042 mem_read high with flush=1 -> no stall, no bus_valid. mem_read held high through DONE -> exactly one transaction.
